lfsr_checker: RTL

Serial receive-side checker for the 8-bit LFSR pseudo-random stream used across the design. It consumes one bit per qualified cycle and self-synchronises to the generator sequence without being told the seed. Once locked, it flags and counts bit errors, and it drops lock and re-hunts when errors exceed a windowed limit. It sits at the far end of any link, loopback or display path carrying the generator's feedback-bit stream, and serves as the BIST/link-quality monitor.

---
 rtl/lfsr_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR feedback-bit stream.
// Self-synchronises without a seed, then flywheels, counts bit errors and re-hunts on a windowed error limit.
module lfsr_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        err_clr,
  output logic        locked,
  output logic        bit_err,
  output logic [15:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W:0]    ERR_LIM_X  = (WERR_W + 1)'(ERR_LIMIT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state, state_nx;
  logic [7:0]          h, h_nx, h_in;
  logic [2:0]          fill_cnt, fill_nx;
  logic [MATCH_W-1:0]  match_cnt, match_nx;
  logic [WIN_W-1:0]    win_cnt, win_cnt_nx;
  logic [WERR_W-1:0]   win_err, win_err_nx;
  logic [WERR_W:0]     win_sum;
  logic                bit_err_nx;
  logic [15:0]         err_count_nx;
  logic                pred, miss;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pred    = h[7] ^ h[6] ^ h[5] ^ h[0];
  assign miss    = in_bit ^ pred;
  assign h_in    = {h[6:0], in_bit};
  // Errors already in this window plus the one being sampled now.
  assign win_sum = {1'b0, win_err} + {{WERR_W{1'b0}}, miss};

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      h         <= 8'h00;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      bit_err   <= 1'b0;
      err_count <= 16'd0;
    end else begin
      state     <= state_nx;
      h         <= h_nx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      win_cnt   <= win_cnt_nx;
      win_err   <= win_err_nx;
      bit_err   <= bit_err_nx;
      err_count <= err_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    h_nx         = h;
    fill_nx      = fill_cnt;
    match_nx     = match_cnt;
    win_cnt_nx   = win_cnt;
    win_err_nx   = win_err;
    bit_err_nx   = 1'b0;
    err_count_nx = err_clr ? 16'd0 : err_count;

    if (in_valid) begin
      case (state)
        HUNT: begin
          h_nx = h_in;
          if (fill_cnt == 3'd7) begin
            state_nx = VERIFY;
            fill_nx  = '0;
            match_nx = '0;
          end else begin
            fill_nx = fill_cnt + 3'd1;
          end
        end
        VERIFY: begin
          // Received bits are shifted in so the history resynchronises after a slip.
          h_nx = h_in;
          if (h_in == 8'h00) begin
            state_nx = HUNT;
            fill_nx  = '0;
            match_nx = '0;
          end else if (miss) begin
            match_nx = '0;
          end else if (match_cnt == MATCH_LAST) begin
            state_nx   = LOCKED;
            match_nx   = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
          end else begin
            match_nx = match_cnt + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so one corrupted bit costs exactly one error.
          h_nx = {h[6:0], pred};
          if (miss) begin
            bit_err_nx   = 1'b1;
            err_count_nx = err_clr ? 16'd1 : sat_inc(err_count);
          end
          if (win_sum >= ERR_LIM_X) begin
            state_nx   = HUNT;
            fill_nx    = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt_nx = '0;
            win_err_nx = '0;
          end else begin
            win_cnt_nx = win_cnt + WIN_W'(1);
            win_err_nx = win_sum[WERR_W-1:0];
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

endmodule
